// File: rtl/term_loopback_switch_matrix.sv
// term_loopback_switch_matrix: loops N_END back onto S_BEG with per-lane comb/reg/tie modes
// loaded through a serial config chain and committed atomically.
module term_loopback_switch_matrix #(
  parameter int NUM_WIRES = 16,
  parameter bit REVERSE = 1'b1,
  localparam int CFG_BITS = 2 * NUM_WIRES
) (
  input  logic                 UserCLK,
  input  logic                 resetn,
  input  logic [NUM_WIRES-1:0] N_END,
  output logic [NUM_WIRES-1:0] S_BEG,
  input  logic                 cfg_valid,
  input  logic                 cfg_data,
  output logic                 cfg_ready,
  input  logic                 cfg_abort,
  output logic                 cfg_done,
  output logic [CFG_BITS-1:0]  cfg_active
);
  localparam int CW = $clog2(CFG_BITS + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state_q, state_d;
  logic [CFG_BITS-1:0] sreg_q, sreg_d, active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic [NUM_WIRES-1:0] pipe_q, src;
  always_comb begin
    for (int i = 0; i < NUM_WIRES; i++) src[i] = REVERSE ? N_END[NUM_WIRES-1-i] : N_END[i];
  end
  // COMMIT ignores abort and incoming bits so the active word is never torn.
  always_comb begin
    state_d = state_q;
    sreg_d = sreg_q;
    cnt_d = cnt_q;
    active_d = active_q;
    done_d = 1'b0;
    if (state_q == COMMIT) begin
      active_d = sreg_q;
      sreg_d = '0;
      cnt_d = '0;
      state_d = IDLE;
      done_d = 1'b1;
    end else if (cfg_abort) begin
      sreg_d = '0;
      cnt_d = '0;
      state_d = IDLE;
    end else if (cfg_valid) begin
      sreg_d = {sreg_q[CFG_BITS-2:0], cfg_data};
      cnt_d = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(CFG_BITS - 1)) ? COMMIT : SHIFT;
    end
  end
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state_q <= IDLE;
      sreg_q <= '0;
      cnt_q <= '0;
      active_q <= '0;
      done_q <= 1'b0;
      pipe_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
      cnt_q <= cnt_d;
      active_q <= active_d;
      done_q <= done_d;
      pipe_q <= src;
    end
  end
  always_comb begin
    for (int i = 0; i < NUM_WIRES; i++)
      S_BEG[i] = active_q[2*i+1] ? active_q[2*i] : (active_q[2*i] ? pipe_q[i] : src[i]);
  end
  assign cfg_ready = state_q != COMMIT;
  assign cfg_done = done_q;
  assign cfg_active = active_q;
endmodule
